// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial CLA adder sequencer.
package cla_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cla_seq_state_t;

endpackage

// File: rtl/CLA_4_bits.sv
// 4-bit carry-lookahead adder slice: all carries computed directly from generate/propagate.
module CLA_4_bits (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  assign w_c[0] = Cin;
  assign w_c[1] = w_g[0] | (w_p[0] & Cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & Cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

  assign Sum  = w_p ^ w_c[3:0];
  assign Cout = w_c[4];

endmodule

// File: rtl/cla_serial_adder_ctrl.sv
// WIDTH-bit adder built from one CLA_4_bits slice, one nibble per clock, LSB first.
// Define CLA_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module cla_serial_adder_ctrl
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef CLA_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned OFS_W   = IDX_W + $clog2(NIBBLE_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < 8)) begin : g_width_check
    $error("cla_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  cla_seq_state_t r_state, w_state_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic             r_carry, w_carry_next;
  logic [WIDTH-1:0] r_a, w_a_next;
  logic [WIDTH-1:0] r_b, w_b_next;
  logic [WIDTH-1:0] r_sum, w_sum_next;
  logic             r_cout, w_cout_next;

  logic [OFS_W-1:0]    w_ofs;
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_nib_sum;
  logic                w_nib_cout;

  assign w_ofs   = OFS_W'(r_idx) << $clog2(NIBBLE_W);
  assign w_a_nib = r_a[w_ofs +: NIBBLE_W];
  assign w_b_nib = r_b[w_ofs +: NIBBLE_W];

  CLA_4_bits u_cla (
    .A    (w_a_nib),
    .B    (w_b_nib),
    .Cin  (r_carry),
    .Sum  (w_nib_sum),
    .Cout (w_nib_cout)
  );

`ifdef CLA_SEQ_OVF_EN
  logic r_ovf, w_ovf_next;
  logic w_msb_cin;

  // Carry into the top bit of the slice, recovered from the sum bit and its operands.
  assign w_msb_cin = w_nib_sum[NIBBLE_W-1] ^ w_a_nib[NIBBLE_W-1] ^ w_b_nib[NIBBLE_W-1];
  assign ovf       = r_ovf;
`endif

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_carry_next = r_carry;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_sum_next   = r_sum;
    w_cout_next  = r_cout;
`ifdef CLA_SEQ_OVF_EN
    w_ovf_next   = r_ovf;
`endif
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_a_next     = a;
          w_b_next     = b;
          w_carry_next = cin;
          w_idx_next   = '0;
          w_sum_next   = '0;
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_sum_next[w_ofs +: NIBBLE_W] = w_nib_sum;
        w_carry_next = w_nib_cout;
        w_idx_next   = r_idx + 1'b1;
        if (r_idx == LAST_IDX) begin
          w_cout_next  = w_nib_cout;
          w_idx_next   = '0;
          w_state_next = DONE;
`ifdef CLA_SEQ_OVF_EN
          w_ovf_next   = w_msb_cin ^ w_nib_cout;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_carry <= w_carry_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_sum   <= w_sum_next;
      r_cout  <= w_cout_next;
`ifdef CLA_SEQ_OVF_EN
      r_ovf   <= w_ovf_next;
`endif
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// Scoreboard bench for cla_serial_adder_ctrl (WIDTH=16); ovf checks enabled by CLA_SEQ_OVF_EN.
module tb_cla_serial_adder_ctrl;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;
`ifdef CLA_SEQ_OVF_EN
  logic        ovf;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  cla_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef CLA_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mc);
    exp_t        e;
    logic [16:0] full;
    full   = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (ma[15] == mb[15]) && (full[15] != ma[15]);
    return e;
  endfunction

  // Monitor: every result handshake pops and checks one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: actual sum=%h cout=%b, required no output", sum, cout);
      end else begin
        e = sb.pop_front();
        chk("result_sum", {16'd0, sum}, {16'd0, e.sum});
        chk("result_cout", {31'd0, cout}, {31'd0, e.cout});
`ifdef CLA_SEQ_OVF_EN
        chk("result_ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                       input exp_t e);
    int k;
    k = 0;
    while (!in_ready && k < 100) begin
      step();
      k++;
    end
    if (!in_ready) chk("issue_timeout_in_ready", 32'd0, 32'd1);
    a        = ia;
    b        = ib;
    cin      = ic;
    in_valid = 1'b1;
    sb.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (!(sb.size() == 0 && in_ready) && k < 100) begin
      step();
      k++;
    end
    if (!(sb.size() == 0 && in_ready)) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_rand;
    logic [15:0] ra, rb;
    logic        rc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_sum", {16'd0, sum}, 32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Basic add with latency: out_valid rises after the 4th edge following acceptance.
    issue(16'h1234, 16'h4321, 1'b0, exp_t'{16'h5555, 1'b0, 1'b0});
    for (int k = 0; k < 4; k++) begin
      chk("latency_out_valid_low", {31'd0, out_valid}, 32'd0);
      chk("latency_busy", {31'd0, busy}, 32'd1);
      step();
    end
    chk("latency_out_valid_high", {31'd0, out_valid}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd1);
    chk("done_sum", {16'd0, sum}, 32'h5555);
    drain();

    issue(16'hFFFF, 16'h0000, 1'b1, exp_t'{16'h0000, 1'b1, 1'b0});
    drain();
    issue(16'hFFFF, 16'hFFFF, 1'b1, exp_t'{16'hFFFF, 1'b1, 1'b0});
    drain();

    // Backpressure in DONE, then back-to-back issue.
    out_ready = 1'b0;
    issue(16'h0F0F, 16'h0101, 1'b1, exp_t'{16'h1011, 1'b0, 1'b0});
    repeat (4) step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_sum", {16'd0, sum}, 32'h1011);
      chk("bp_cout", {31'd0, cout}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    a         = 16'h0002;
    b         = 16'h0003;
    cin       = 1'b0;
    in_valid  = 1'b1;
    sb.push_back(exp_t'{16'h0005, 1'b0, 1'b0});
    step();
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("bp_next_accepted_busy", {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
    drain();

    // Operands offered during RUN must wait for IDLE.
    issue(16'h0001, 16'h0001, 1'b0, exp_t'{16'h0002, 1'b0, 1'b0});
    a        = 16'hAAAA;
    b        = 16'h5555;
    cin      = 1'b0;
    in_valid = 1'b1;
    sb.push_back(exp_t'{16'hFFFF, 1'b0, 1'b0});
    for (int k = 0; k < 20 && !in_ready; k++) step();
    chk("ignored_wait_idle", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("ignored_second_accepted", {31'd0, busy}, 32'd1);
    drain();

    // Asynchronous reset at idx=2 discards the operation.
    issue(16'h1234, 16'h1111, 1'b0, exp_t'{16'h2345, 1'b0, 1'b0});
    step();
    step();
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, sum}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("midrst_no_output", {31'd0, out_valid}, 32'd0);
    issue(16'h00FF, 16'h0001, 1'b0, exp_t'{16'h0100, 1'b0, 1'b0});
    drain();

`ifdef CLA_SEQ_OVF_EN
    issue(16'h7FFF, 16'h0001, 1'b0, exp_t'{16'h8000, 1'b0, 1'b1});
    drain();
    issue(16'h8000, 16'h8000, 1'b0, exp_t'{16'h0000, 1'b1, 1'b1});
    drain();
    n_rand = 10000;
`else
    n_rand = 2000;
`endif

    for (int i = 0; i < n_rand; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      issue(ra, rb, rc, model(ra, rb, rc));
      drain();
    end

    repeat (3) step();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_serial_adder_ctrl.md
Name: cla_serial_adder_ctrl

Overview:
- Sequencer that performs one WIDTH-bit addition using a single 4-bit carry-lookahead slice (CLA_4_bits).
- Processes one nibble per clock, LSB first, and keeps the inter-nibble carry in a register.
- Provides valid/ready handshakes on both the operand and result sides.
- Used where area matters more than latency; it is the datapath controller for the existing CLA slice.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8 (elaboration-time assertion).
- NIBBLES, WIDTH/4, derived localparam; number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b/cin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to nibble 0
- out_valid  output  1  sum/cout are valid
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  registered result
- cout  output  1  carry out of the top nibble
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset values (rst_n low, async):
  - state=IDLE, idx=0, carry=0.
  - Operand registers, sum and cout are 0.
  - out_valid=0, busy=0, in_ready=1 (decoded from IDLE).
- FSM states: IDLE, RUN, DONE. in_ready=(state==IDLE); out_valid=(state==DONE); busy=!IDLE.
- IDLE: on in_valid&&in_ready, latch a, b, carry<=cin, idx<=0, clear sum, go to RUN. Otherwise hold.
- RUN, each cycle:
  - CLA slice gets A=a_q[4*idx+:4], B=b_q[4*idx+:4], Cin=carry.
  - sum[4*idx+:4]<=Sum; carry<=Cout; idx<=idx+1.
  - When idx==NIBBLES-1: cout<=Cout, go to DONE.
- DONE: hold sum and cout stable while out_valid=1. On out_ready go to IDLE. in_ready stays 0 in DONE; results and new operands never overlap.
- Latency: with acceptance at edge T, out_valid rises after edge T+NIBBLES. Minimum issue interval is NIBBLES+2 cycles (IDLE→RUN×NIBBLES→DONE→IDLE).
- Arithmetic: {cout,sum} equals a+b+cin modulo 2^(WIDTH+1), unsigned. idx width is $clog2(NIBBLES), and idx returns to 0 on the DONE transition.
- in_valid or operand changes during RUN/DONE are ignored; operands are captured only at acceptance.
- out_ready high outside DONE has no effect.
- Reset mid-operation: the operation is discarded and all state returns to reset values immediately. Nothing is emitted after release.
- out_ready held low indefinitely: the block stays in DONE with stable outputs (no timeout).

Optional Feature:
- Macro CLA_SEQ_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), signed two's-complement overflow of the full WIDTH add.
  - ovf = carry into the MSB XOR cout, registered at the DONE transition.
  - Valid with out_valid; reset 0.
- Undefined: no ovf port, no extra flops.

Decomposition:
- Package cla_seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} cla_seq_state_t.
  - Constant NIBBLE_W=4.
- One sub-module instance: the existing CLA_4_bits slice, with ports A, B, Cin, Sum, Cout. No other hierarchy.

Test Plan (WIDTH=16):
- Basic add: a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0. out_valid rises 4 cycles after the acceptance edge; busy high throughout.
- Full ripple: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1. a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1.
- Backpressure: out_ready low for 5 cycles in DONE → out_valid, sum and cout stable, in_ready=0. Raising out_ready → IDLE next cycle; the next operand pair is accepted the following cycle.
- Ignored input: accept a=0x0001, b=0x0001; then drive in_valid=1 with a=0xAAAA during RUN → result sum=0x0002, and the second pair is only taken after returning to IDLE.
- Reset mid-op: assert rst_n at idx=2 → out_valid=0, sum=0, cout=0, busy=0, in_ready=1 asynchronously. After release, a=0x00FF, b=0x0001 → sum=0x0100.
- With CLA_SEQ_OVF_EN:
  - a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, cout=0.
  - a=0x8000, b=0x8000 → sum=0x0000, ovf=1, cout=1.
  - Bench also runs 10k random operand triples against the a+b+cin reference with zero mismatches.
